// File: rtl/instr_mem_sync_pkg.sv
// Shared types and helpers for the fetch-stage instruction memory.
package instr_mem_sync_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Index width for a DEPTH-entry array; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_mem_sync_array.sv
// Single-write, single-read synchronous RAM with a registered read port.
module imem_array #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset so a program survives a core reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory: loader fills words in LOAD, PC-addressed fetches in RUN.
module instr_mem_sync
    import instr_mem_sync_pkg::*;
#(
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 64,
    parameter int unsigned   PC_W     = 8,
    parameter logic [DW-1:0] NOP_WORD = DW'(NOP_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [DW-1:0]   prog_data,
    input  logic            prog_done,
    input  logic            fetch_req,
    input  logic [PC_W-1:0] fetch_addr,
    input  logic            stall,
    output logic [DW-1:0]   instr_out,
    output logic            instr_valid,
    output logic            addr_fault,
    output logic            running
);

    localparam int unsigned IW = idx_width(DEPTH);

    imem_state_t   state_q, state_d;
    logic          wr_ok, rd_ok, accept;
    logic          show_nop;
    logic [DW-1:0] rdata;

    // Range checks use the full PC_W value before any truncation to IW bits.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        case (state_q)
            LOAD: begin
                wr_ok = prog_we && (32'(prog_addr) < DEPTH);
                if (prog_done) state_d = RUN;
            end
            RUN: begin
                accept = fetch_req && !stall;
                rd_ok  = accept && (32'(fetch_addr) < DEPTH);
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
            show_nop    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == RUN && !stall) begin
                instr_valid <= fetch_req;
                addr_fault  <= accept && !rd_ok;
                if (accept) show_nop <= !rd_ok;
            end
        end
    end

    imem_array #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (prog_addr[IW-1:0]),
        .wdata (prog_data),
        .re    (rd_ok),
        .raddr (fetch_addr[IW-1:0]),
        .rdata (rdata)
    );

    // RAM output only advances on in-range accepts, so it already holds otherwise.
    assign instr_out = show_nop ? NOP_WORD : rdata;
    assign running   = (state_q == RUN);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed plus randomized bench for instr_mem_sync against a behavioural model.
module tb_instr_mem_sync;

    localparam int DW = 32, DEPTH = 64, PC_W = 8;

    logic            clk = 1'b0;
    logic            rst, prog_we, prog_done, fetch_req, stall;
    logic [PC_W-1:0] prog_addr, fetch_addr;
    logic [DW-1:0]   prog_data;
    logic [DW-1:0]   instr_out;
    logic            instr_valid, addr_fault, running;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_wr  [DEPTH];
    bit            m_run, m_valid, m_fault, m_known;
    logic [DW-1:0] m_out;

    instr_mem_sync #(.DW(DW), .DEPTH(DEPTH), .PC_W(PC_W), .NOP_WORD('0)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_done(prog_done), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .stall(stall), .instr_out(instr_out),
        .instr_valid(instr_valid), .addr_fault(addr_fault), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_valid = 0; m_fault = 0; m_out = '0; m_known = 1;
        end else if (!m_run) begin
            if (prog_we && prog_addr < DEPTH) begin
                ref_mem[prog_addr] = prog_data;
                ref_wr[prog_addr]  = 1;
            end
            if (prog_done) m_run = 1;
        end else if (!stall) begin
            if (fetch_req) begin
                m_valid = 1;
                if (fetch_addr >= DEPTH) begin
                    m_fault = 1; m_out = '0; m_known = 1;
                end else begin
                    m_fault = 0; m_out = ref_mem[fetch_addr]; m_known = ref_wr[fetch_addr];
                end
            end else begin
                m_valid = 0; m_fault = 0;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("running", DW'(running), DW'(m_run));
        chk("instr_valid", DW'(instr_valid), DW'(m_valid));
        chk("addr_fault", DW'(addr_fault), DW'(m_fault));
        if (m_known) chk("instr_out", instr_out, m_out);
    endtask

    task automatic idle();
        rst = 0; prog_we = 0; prog_addr = '0; prog_data = '0; prog_done = 0;
        fetch_req = 0; fetch_addr = '0; stall = 0;
    endtask

    task automatic load(input logic [PC_W-1:0] a, input logic [DW-1:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        cycle();
        prog_we = 0;
    endtask

    task automatic fetch(input logic [PC_W-1:0] a);
        fetch_req = 1; fetch_addr = a;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_wr[i] = 0;
        m_run = 0; m_valid = 0; m_fault = 0; m_out = '0; m_known = 0;
        idle();

        // Reset state
        rst = 1; cycle(); cycle(); rst = 0;
        chk("rst_out", instr_out, 32'h0);
        chk("rst_valid", DW'(instr_valid), 32'h0);
        chk("rst_running", DW'(running), 32'h0);

        // Load, with fetch attempts and an out-of-range write while loading
        load(8'd0, 32'h0020_0003);
        load(8'd1, 32'h0020_0002);
        load(8'd2, 32'h1064_0022);
        load(8'd6, 32'h0000_0066);
        fetch(8'd0);
        chk("load_fetch_ignored", DW'(instr_valid), 32'h0);
        fetch_req = 0;
        load(8'd70, 32'hDEAD_BEEF);
        prog_done = 1; cycle(); prog_done = 0;
        chk("run_entered", DW'(running), 32'h1);

        // Back-to-back fetches
        fetch(8'd0); chk("b2b_0", instr_out, 32'h0020_0003);
        fetch(8'd1); chk("b2b_1", instr_out, 32'h0020_0002);
        fetch(8'd2); chk("b2b_2", instr_out, 32'h1064_0022);

        // Stall holds the previous response
        stall = 1; fetch_addr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_out", instr_out, 32'h1064_0022);
            chk("stall_valid", DW'(instr_valid), 32'h1);
        end
        stall = 0; cycle(); chk("post_stall", instr_out, 32'h0020_0003);

        // Out of range
        fetch(8'd64);  chk("oor64_out", instr_out, 32'h0); chk("oor64_fault", DW'(addr_fault), 32'h1);
        fetch(8'd255); chk("oor255_fault", DW'(addr_fault), 32'h1);
        fetch(8'd1);   chk("after_oor", instr_out, 32'h0020_0002); chk("after_oor_fault", DW'(addr_fault), 32'h0);

        // Writes in RUN are ignored; address 70 did not alias onto 6
        fetch_req = 0; load(8'd0, 32'hFFFF_FFFF);
        chk("idle_valid", DW'(instr_valid), 32'h0);
        fetch(8'd0); chk("run_write_ignored", instr_out, 32'h0020_0003);
        fetch(8'd6); chk("oor_write_dropped", instr_out, 32'h0000_0066);

        // Reset while streaming, then resume with retained contents
        fetch(8'd1);
        rst = 1; cycle(); rst = 0;
        chk("midrst_valid", DW'(instr_valid), 32'h0);
        chk("midrst_running", DW'(running), 32'h0);
        chk("midrst_out", instr_out, 32'h0);
        fetch_req = 0; prog_done = 1; cycle(); prog_done = 0;
        fetch(8'd1); chk("retained", instr_out, 32'h0020_0002);

        // Write and done in the same cycle
        fetch_req = 0; rst = 1; cycle(); rst = 0;
        prog_we = 1; prog_addr = 8'd5; prog_data = 32'hABCD_0001; prog_done = 1;
        cycle(); prog_we = 0; prog_done = 0;
        chk("same_cycle_running", DW'(running), 32'h1);
        fetch(8'd5); chk("same_cycle_data", instr_out, 32'hABCD_0001);

        // Randomized: full reload then mixed traffic with stray loader activity and resets
        idle(); rst = 1; cycle(); rst = 0;
        for (int i = 0; i < DEPTH; i++) load(PC_W'(i), DW'($urandom));
        load(PC_W'($urandom_range(64, 255)), DW'($urandom));
        prog_done = 1; cycle(); prog_done = 0;
        for (int i = 0; i < 500; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            fetch_req  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            fetch_addr = ($urandom_range(0, 4) == 0) ? PC_W'($urandom_range(64, 255))
                                                     : PC_W'($urandom_range(0, DEPTH - 1));
            prog_we    = ($urandom_range(0, 3) == 0);
            prog_addr  = PC_W'($urandom_range(0, 80));
            prog_data  = DW'($urandom);
            prog_done  = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
